// File: rtl/game_pkg.sv
// Shared types and constants for the reflex game blocks.
// Used by the judge, random pattern and score counter units.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    WAIT_CHANGE,
    DONE
  } judge_state_t;

  localparam int GAME_WIDTH      = 8;
  localparam int DEB_SAMPLES_DEF = 4;

endpackage

// File: rtl/switch_debounce.sv
// Switch synchroniser and per-bit debounce filter.
// MATCH_JUDGE_DEBOUNCE_EN: counted filter; else one-sample filter.
module switch_debounce #(
  parameter int WIDTH       = 8,
  parameter int DEB_SAMPLES = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             scan_tick,
  input  logic [WIDTH-1:0] switch,
  output logic [WIDTH-1:0] sw_db
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  if (DEB_SAMPLES < 2) begin : g_bad_samples
    $error("switch_debounce: DEB_SAMPLES must be >= 2");
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge clk) begin
    if (clr) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch;
      sync2 <= sync1;
    end
  end

`ifdef MATCH_JUDGE_DEBOUNCE_EN

  localparam int CW = $clog2(DEB_SAMPLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEB_SAMPLES - 1);
  localparam logic [CW-1:0] TOP  = CW'(DEB_SAMPLES);

  logic [CW-1:0] cnt [WIDTH];

  // Bit flips only after DEB_SAMPLES differing samples in a row
  always_ff @(posedge clk) begin
    if (clr) begin
      sw_db <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
    end else if (scan_tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == sw_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] >= LAST) begin
          sw_db[i] <= sync2[i];
          cnt[i]   <= '0;
        end else if (cnt[i] != TOP) begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

`else

  // One-sample filter: take the synchronised value every tick
  always_ff @(posedge clk) begin
    if (clr) begin
      sw_db <= '0;
    end else if (scan_tick) begin
      sw_db <= sync2;
    end
  end

`endif

endmodule

// File: rtl/match_judge.sv
// Round judge: one success per round when switches hit the LEDs.
// Option macro MATCH_JUDGE_DEBOUNCE_EN selects the counted debounce.
module match_judge
  import game_pkg::*;
#(
  parameter int WIDTH       = GAME_WIDTH,
  parameter int DEB_SAMPLES = DEB_SAMPLES_DEF
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             key_scan,
  input  logic             Time_1s,
  input  logic [WIDTH-1:0] switch,
  input  logic [WIDTH-1:0] led_control,
  output logic             success,
  output logic             miss,
  output logic             round_active,
  output logic [WIDTH-1:0] sw_db
);

  logic key_q, key_d, scan_tick;
  logic t_q, t_d, round_tick;
  logic [WIDTH-1:0] pattern_q;
  judge_state_t state;

  // Register strobes and form one-cycle rising-edge pulses
  always_ff @(posedge clk) begin
    if (clr) begin
      key_q      <= 1'b0;
      key_d      <= 1'b0;
      scan_tick  <= 1'b0;
      t_q        <= 1'b0;
      t_d        <= 1'b0;
      round_tick <= 1'b0;
    end else begin
      key_q      <= key_scan;
      key_d      <= key_q;
      scan_tick  <= key_q & ~key_d;
      t_q        <= Time_1s;
      t_d        <= t_q;
      round_tick <= t_q & ~t_d;
    end
  end

  switch_debounce #(
    .WIDTH       (WIDTH),
    .DEB_SAMPLES (DEB_SAMPLES)
  ) u_deb (
    .clk       (clk),
    .clr       (clr),
    .scan_tick (scan_tick),
    .switch    (switch),
    .sw_db     (sw_db)
  );

  // Round FSM; a round boundary overrides any compare that cycle
  always_ff @(posedge clk) begin
    if (clr) begin
      state        <= IDLE;
      pattern_q    <= '0;
      success      <= 1'b0;
      miss         <= 1'b0;
      round_active <= 1'b0;
    end else begin
      success <= 1'b0;
      miss    <= 1'b0;
      if (round_tick) begin
        pattern_q    <= led_control;
        miss         <= (state == ARMED) ||
                        (state == WAIT_CHANGE);
        round_active <= 1'b1;
        if (sw_db == led_control) state <= WAIT_CHANGE;
        else                      state <= ARMED;
      end else begin
        unique case (state)
          IDLE: ;
          WAIT_CHANGE: begin
            if (sw_db != pattern_q) state <= ARMED;
          end
          ARMED: begin
            if (sw_db == pattern_q) begin
              success      <= 1'b1;
              round_active <= 1'b0;
              state        <= DONE;
            end
          end
          DONE: ;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/match_judge.md
# match_judge

Round-based judge for the reflex game: synchronises and debounces the 8 player switches, latches the LED pattern at each 1 s round boundary, and emits exactly one `success` pulse per round when the debounced switches equal the pattern. Sits between the clock divider / LED pattern generator and the 4-digit decimal score counter chain. Its `success` output drives the units counter.

## Interface
Parameters:
- `WIDTH`, 8: number of switches and LEDs.
- `DEB_SAMPLES`, 4: consecutive identical `key_scan` samples needed before a debounced bit changes (≥2).

Ports:
- `clk`  in  1  system clock; sole clock of the block.
- `clr`  in  1  reset, synchronous, active-high.
- `key_scan`  in  1  ~20 ms square wave from the clock divider; its rising edge is the sample strobe.
- `Time_1s`  in  1  ~1 s square wave; its rising edge is the round boundary.
- `switch`  in  WIDTH  raw, asynchronous player switches.
- `led_control`  in  WIDTH  current LED pattern, stable away from `Time_1s` edges.
- `success`  out  1  one-`clk` pulse per won round; drives the score counter.
- `miss`  out  1  one-`clk` pulse when a round closes without a win.
- `round_active`  out  1  high while the current round can still be won.
- `sw_db`  out  WIDTH  debounced switch state.

## Operation
- Input conditioning: `switch` passes through a 2-flop synchroniser. `key_scan` and `Time_1s` are each registered once, and rising edges are detected in `clk` to form `scan_tick` and `round_tick` (1-cycle pulses).
- Debounce, per bit: on `scan_tick`, compare the synchronised bit with `sw_db[i]`.
  - If they differ, increment that bit's counter. When it reaches DEB_SAMPLES, set `sw_db[i]` to the new value and clear the counter.
  - If they are equal, clear the counter.
- Counter width: `$clog2(DEB_SAMPLES+1)`. Counters saturate and never wrap.
- FSM states: IDLE, ARMED, WAIT_CHANGE, DONE.
  - IDLE: state after reset. On `round_tick`, go to round open.
  - Round open (from any state on `round_tick`):
    - Latch `pattern_q <= led_control`.
    - If the previous state was ARMED or WAIT_CHANGE, pulse `miss`.
    - Next state is WAIT_CHANGE if `sw_db == led_control`, otherwise ARMED. Switches already matching at round open earn no point.
  - WAIT_CHANGE: go to ARMED when `sw_db != pattern_q`.
  - ARMED: when `sw_db == pattern_q`, pulse `success` and go to DONE.
  - DONE: wait for `round_tick`.
- `round_active` is high in ARMED and WAIT_CHANGE.
- Simultaneous events:
  - `round_tick` has priority over any compare in the same cycle. A match against the old pattern in that cycle is discarded and counts as a `miss`.
  - `clr` has priority over everything.
- All-zero pattern: the generator never produces one. If it does, it is treated as an ordinary pattern.

## Timing
- Reset values: `success`=0, `miss`=0, `round_active`=0, `sw_db`=0. State is IDLE, `pattern_q`=0, counters=0, synchroniser and edge registers=0.
- `Time_1s` rising at the input → `round_tick` 2 `clk` later → `pattern_q`, state and `miss` update on the following edge.
- `sw_db` change → `success` registered 1 `clk` later.
- `success` and `miss` are registered, exactly one cycle wide, and never high together.
- `clr` asserted mid-round: on the next `clk` everything returns to reset values. Any pending `success` or `miss` is dropped.
- Per-bit debounce latency: DEB_SAMPLES `scan_tick`s after the bit settles, plus up to 3 `clk`.

## Configuration
- `MATCH_JUDGE_DEBOUNCE_EN`
  - Defined: debounce exactly as above.
  - Undefined: counters are removed, and `sw_db` follows the synchronised switches on every `scan_tick` (one-sample filter). The FSM is unchanged.

## Structure
- Shared package `game_pkg`:
  - FSM state enum `judge_state_t`.
  - Constants `GAME_WIDTH=8` and `DEB_SAMPLES_DEF=4`, also used by the random and score blocks.
- One sub-module `switch_debounce`, parameterised by WIDTH and DEB_SAMPLES. It contains the synchroniser, counters and `sw_db`, and takes `scan_tick` as input.
- Edge detection and the FSM stay in `match_judge`.

## Test plan
- Reset: hold `clr` for 3 cycles with random switches → all outputs 0 and state IDLE. No `success` appears until the first `round_tick`.
- Basic win: `led_control`=8'h07, switches 0 at round open, then switches set to 8'h07 for ≥4 `scan_tick`s → exactly one `success`, `round_active` falls, and no `miss` at the next round.
- Bounce: toggle `switch[0]` every `scan_tick` 10 times, then hold at 1 → `sw_db[0]` changes only after 4 stable samples and no spurious `success` occurs. With the macro undefined, `sw_db[0]` follows each sample.
- Pre-matched switches: switches already 8'h0E when a round opens with pattern 8'h0E → no `success`. Clear one switch, then restore it → one `success`.
- Miss and collision: pattern 8'h1C never matched → `miss` pulses in the same cycle the next round opens. A match in the same cycle as `round_tick` → `miss`, no `success`.
- Reset mid-round: `clr` one cycle before a match completes → no `success`, and outputs return to reset values.
